// File: rtl/div_16bit_seq_pkg.sv
// Shared definitions for the sequential 16-bit divider.
// Contents: data width, iteration count, counter width and the controller state encoding.
package div_16bit_seq_pkg;

   localparam int unsigned data_width = 16;
   localparam int unsigned num_iters  = 16;
   localparam int unsigned cnt_width  = $clog2(num_iters);

   typedef enum logic [1:0] {
      st_idle,
      st_run,
      st_done
   } state_e;

endpackage

// File: rtl/div_16bit_seq_if.sv
// Requester/result bundle for div_16bit_seq.
// master: two requesters (req/a/b out, grants and results in).
// slave : the divider (req/a/b in, gnt0/gnt1/busy/valid/id/quotient/remainder/div0 out).
interface div_16bit_seq_if;
   import div_16bit_seq_pkg::*;

   logic                  req0;
   logic [data_width-1:0] a0;
   logic [data_width-1:0] b0;
   logic                  req1;
   logic [data_width-1:0] a1;
   logic [data_width-1:0] b1;
   logic                  gnt0;
   logic                  gnt1;
   logic                  busy;
   logic                  valid;
   logic                  id;
   logic [data_width-1:0] quotient;
   logic [data_width-1:0] remainder;
   logic                  div0;

   modport master (
      output req0, a0, b0, req1, a1, b1,
      input  gnt0, gnt1, busy, valid, id, quotient, remainder, div0
   );

   modport slave (
      input  req0, a0, b0, req1, a1, b1,
      output gnt0, gnt1, busy, valid, id, quotient, remainder, div0
   );

endinterface

// File: rtl/div_16bit_step.sv
// One restoring-division iteration (combinational).
// Ports: rem_in (partial remainder), dividend_bit (next dividend bit, MSB first), divisor,
//        rem_out (updated partial remainder), quot_bit (quotient bit for this iteration).
module div_16bit_step
   import div_16bit_seq_pkg::*;
(
   input  logic [data_width-1:0] rem_in,
   input  logic                  dividend_bit,
   input  logic [data_width-1:0] divisor,
   output logic [data_width-1:0] rem_out,
   output logic                  quot_bit
);

   // One extra bit so the shifted-out remainder MSB still takes part in the compare.
   logic [data_width:0] shifted;
   logic [data_width:0] diff;

   always_comb begin
      shifted  = {rem_in, dividend_bit};
      diff     = shifted - {1'b0, divisor};
      quot_bit = (shifted >= {1'b0, divisor});
      // After a subtract the result is below the divisor, so it always fits in data_width bits.
      rem_out  = quot_bit ? diff[data_width-1:0] : shifted[data_width-1:0];
   end

endmodule

// File: rtl/div_16bit_seq.sv
// Two-requester sequential unsigned divider, one quotient bit per clock.
// Ports: clk, rst (synchronous, active-high),
//        bus (slave modport): req0/a0/b0, req1/a1/b1 in; gnt0/gnt1 (combinational, IDLE only),
//        busy, valid (DONE pulse), id, quotient, remainder, div0 out (registered).
// A grant in cycle T gives valid in cycle T+17; results hold until the next DONE.
module div_16bit_seq
   import div_16bit_seq_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   div_16bit_seq_if.slave        bus
);

   state_e                state_q;
   logic [cnt_width-1:0]  cnt_q;
   logic                  last_q;     // requester granted most recently
   logic                  own_id_q;
   logic [data_width-1:0] divisor_q;
   logic [data_width-1:0] work_q;     // dividend shifts out the top, quotient fills the bottom
   logic [data_width-1:0] rem_q;

   logic                  busy_q;
   logic                  valid_q;
   logic                  id_q;
   logic [data_width-1:0] quot_out_q;
   logic [data_width-1:0] rem_out_q;
   logic                  div0_q;

   logic                  pick0;
   logic                  pick1;
   logic [data_width-1:0] rem_nxt;
   logic                  qbit;

   // Round-robin arbiter; reset wins over any request.
   always_comb begin
      pick0 = 1'b0;
      pick1 = 1'b0;
      if (state_q == st_idle && !rst) begin
         if (bus.req0 && bus.req1) begin
            pick0 = last_q;
            pick1 = !last_q;
         end else begin
            pick0 = bus.req0;
            pick1 = bus.req1;
         end
      end
   end

   div_16bit_step u_step (
      .rem_in       (rem_q),
      .dividend_bit (work_q[data_width-1]),
      .divisor      (divisor_q),
      .rem_out      (rem_nxt),
      .quot_bit     (qbit)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= st_idle;
         cnt_q      <= '0;
         last_q     <= 1'b1;   // requester 0 wins the first tie
         own_id_q   <= 1'b0;
         divisor_q  <= '0;
         work_q     <= '0;
         rem_q      <= '0;
         busy_q     <= 1'b0;
         valid_q    <= 1'b0;
         id_q       <= 1'b0;
         quot_out_q <= '0;
         rem_out_q  <= '0;
         div0_q     <= 1'b0;
      end else begin
         unique case (state_q)
            st_idle: begin
               if (pick0 || pick1) begin
                  state_q   <= st_run;
                  cnt_q     <= '0;
                  rem_q     <= '0;
                  work_q    <= pick1 ? bus.a1 : bus.a0;
                  divisor_q <= pick1 ? bus.b1 : bus.b0;
                  own_id_q  <= pick1;
                  last_q    <= pick1;
                  busy_q    <= 1'b1;
               end
            end
            st_run: begin
               work_q <= {work_q[data_width-2:0], qbit};
               rem_q  <= rem_nxt;
               cnt_q  <= cnt_q + 1'b1;
               if (cnt_q == cnt_width'(num_iters - 1)) begin
                  state_q    <= st_done;
                  valid_q    <= 1'b1;
                  quot_out_q <= {work_q[data_width-2:0], qbit};
                  rem_out_q  <= rem_nxt;
                  id_q       <= own_id_q;
                  div0_q     <= (divisor_q == '0);
               end
            end
            st_done: begin
               state_q <= st_idle;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: state_q <= st_idle;
         endcase
      end
   end

   assign bus.gnt0      = pick0;
   assign bus.gnt1      = pick1;
   assign bus.busy      = busy_q;
   assign bus.valid     = valid_q;
   assign bus.id        = id_q;
   assign bus.quotient  = quot_out_q;
   assign bus.remainder = rem_out_q;
   assign bus.div0      = div0_q;

endmodule

// File: tb/tb_div_16bit_seq.sv
// Self-checking bench for div_16bit_seq. Inputs change 1 time unit after the rising edge,
// outputs are sampled on the falling edge. Every grant pushes an expected result onto a
// scoreboard queue; every valid pops and compares it, including the 17-cycle latency.
module tb_div_16bit_seq;
   import div_16bit_seq_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   div_16bit_seq_if bus ();

   div_16bit_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        id;
      logic [15:0] q;
      logic [15:0] r;
      logic        d0;
      int          due;
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;

   logic        s_gnt0, s_gnt1, s_busy, s_valid, s_id, s_div0;
   logic [15:0] s_q, s_r;
   int          s_cyc;

   // Sample at the falling edge, run the scoreboard, then move to just after the next rising edge.
   task automatic tick();
      exp_t        e;
      logic [15:0] a, b;
      @(negedge clk);
      s_cyc   = cyc;
      s_gnt0  = bus.gnt0;
      s_gnt1  = bus.gnt1;
      s_busy  = bus.busy;
      s_valid = bus.valid;
      s_id    = bus.id;
      s_q     = bus.quotient;
      s_r     = bus.remainder;
      s_div0  = bus.div0;
      if (s_gnt0 || s_gnt1) begin
         vectors++;
         if (s_gnt0 && s_gnt1) begin
            miscompares++;
            $display("FAIL gnt_exclusive: cycle %0d gnt0=%b gnt1=%b, required one-hot",
                     s_cyc, s_gnt0, s_gnt1);
         end
         a    = s_gnt1 ? bus.a1 : bus.a0;
         b    = s_gnt1 ? bus.b1 : bus.b0;
         e.id = s_gnt1;
         e.d0 = (b == 16'd0);
         e.q  = e.d0 ? 16'hffff : a / b;
         e.r  = e.d0 ? a : a % b;
         e.due = s_cyc + 17;
         sb.push_back(e);
      end
      if (s_valid) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL spurious_valid: cycle %0d valid=1, required no pending operation", s_cyc);
         end else begin
            e = sb.pop_front();
            if ({s_id, s_q, s_r, s_div0} !== {e.id, e.q, e.r, e.d0}) begin
               miscompares++;
               $display("FAIL result: id=%b q=%h r=%h div0=%b, required id=%b q=%h r=%h div0=%b",
                        s_id, s_q, s_r, s_div0, e.id, e.q, e.r, e.d0);
            end
            vectors++;
            if (s_cyc != e.due) begin
               miscompares++;
               $display("FAIL latency: valid at cycle %0d, required %0d", s_cyc, e.due);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input bit which, input logic [15:0] a, input logic [15:0] b,
                        output int t);
      bit got = 1'b0;
      t = -1;
      if (which) begin
         bus.req1 = 1'b1; bus.a1 = a; bus.b1 = b;
      end else begin
         bus.req0 = 1'b1; bus.a0 = a; bus.b0 = b;
      end
      for (int i = 0; i < 40 && !got; i++) begin
         tick();
         if (which ? s_gnt1 : s_gnt0) begin
            got = 1'b1;
            t   = s_cyc;
         end
      end
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      vectors++;
      if (!got) begin
         miscompares++;
         $display("FAIL grant_timeout: requester %0d got no grant, required one", which);
      end
   endtask

   task automatic wait_valid(output int t);
      bit got = 1'b0;
      t = -1;
      for (int i = 0; i < 40 && !got; i++) begin
         tick();
         if (s_valid) begin
            got = 1'b1;
            t   = s_cyc;
         end
      end
      vectors++;
      if (!got) begin
         miscompares++;
         $display("FAIL valid_timeout: no valid within 40 cycles, required one");
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      vectors++;
      if ({s_gnt0, s_gnt1, s_busy, s_valid, s_id, s_div0} !== 6'b0) begin
         miscompares++;
         $display("FAIL %s_ctrl: gnt0=%b gnt1=%b busy=%b valid=%b id=%b div0=%b, required all 0",
                  tag, s_gnt0, s_gnt1, s_busy, s_valid, s_id, s_div0);
      end
      vectors++;
      if (s_q !== 16'd0 || s_r !== 16'd0) begin
         miscompares++;
         $display("FAIL %s_data: q=%h r=%h, required 0000 0000", tag, s_q, s_r);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
      check_reset_outputs("reset");
   endtask

   task automatic test_basic();
      int t, tv;
      issue(1'b0, 16'd100, 16'd7, t);
      tick();
      vectors++;
      if (s_busy !== 1'b1) begin
         miscompares++;
         $display("FAIL busy_run: busy=%b, required 1", s_busy);
      end
      wait_valid(tv);
      vectors++;
      if (tv != t + 17 || s_busy !== 1'b1) begin
         miscompares++;
         $display("FAIL basic_timing: valid at %0d busy=%b, required %0d busy=1", tv, s_busy, t + 17);
      end
      vectors++;
      if (s_q !== 16'd14 || s_r !== 16'd2 || s_id !== 1'b0 || s_div0 !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_result: q=%0d r=%0d id=%b div0=%b, required 14 2 0 0",
                  s_q, s_r, s_id, s_div0);
      end
      tick();
      vectors++;
      if (s_valid !== 1'b0 || s_busy !== 1'b0 || s_q !== 16'd14 || s_r !== 16'd2) begin
         miscompares++;
         $display("FAIL basic_hold: valid=%b busy=%b q=%0d r=%0d, required 0 0 14 2",
                  s_valid, s_busy, s_q, s_r);
      end
   endtask

   task automatic test_req1();
      int t, tv;
      issue(1'b1, 16'hffff, 16'd1, t);
      wait_valid(tv);
      vectors++;
      if (s_q !== 16'hffff || s_r !== 16'd0 || s_id !== 1'b1) begin
         miscompares++;
         $display("FAIL req1_max: q=%h r=%h id=%b, required ffff 0000 1", s_q, s_r, s_id);
      end
      issue(1'b1, 16'd5, 16'd9, t);
      wait_valid(tv);
      vectors++;
      if (s_q !== 16'd0 || s_r !== 16'd5 || s_id !== 1'b1) begin
         miscompares++;
         $display("FAIL req1_small: q=%0d r=%0d id=%b, required 0 5 1", s_q, s_r, s_id);
      end
   endtask

   task automatic test_div0();
      int t, tv;
      issue(1'b0, 16'd1234, 16'd0, t);
      wait_valid(tv);
      vectors++;
      if (tv != t + 17 || s_q !== 16'hffff || s_r !== 16'd1234 || s_div0 !== 1'b1) begin
         miscompares++;
         $display("FAIL div0: cycle %0d q=%h r=%0d div0=%b, required cycle %0d ffff 1234 1",
                  tv, s_q, s_r, s_div0, t + 17);
      end
   endtask

   task automatic test_round_robin();
      int gc[3];
      bit gi[3];
      int n = 0;
      int tv;
      rst = 1'b1;
      bus.req0 = 1'b1; bus.a0 = 16'd200; bus.b0 = 16'd3;
      bus.req1 = 1'b1; bus.a1 = 16'd999; bus.b1 = 16'd10;
      tick();
      vectors++;
      if (s_gnt0 !== 1'b0 || s_gnt1 !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_priority: gnt0=%b gnt1=%b under reset, required 0 0", s_gnt0, s_gnt1);
      end
      rst = 1'b0;
      for (int i = 0; i < 60 && n < 3; i++) begin
         tick();
         if (s_gnt0 || s_gnt1) begin
            gc[n] = s_cyc;
            gi[n] = s_gnt1;
            n++;
         end
      end
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      vectors++;
      if (n != 3) begin
         miscompares++;
         $display("FAIL rr_count: %0d grants seen, required 3", n);
      end else begin
         vectors++;
         if (gi[0] !== 1'b0 || gi[1] !== 1'b1 || gi[2] !== 1'b0) begin
            miscompares++;
            $display("FAIL rr_order: ids %0d %0d %0d, required 0 1 0", gi[0], gi[1], gi[2]);
         end
         vectors++;
         if (gc[1] - gc[0] != 18 || gc[2] - gc[1] != 18) begin
            miscompares++;
            $display("FAIL rr_spacing: gaps %0d %0d, required 18 18", gc[1] - gc[0], gc[2] - gc[1]);
         end
      end
      wait_valid(tv);
   endtask

   task automatic test_abort();
      int  t, tv;
      bit  saw = 1'b0;
      issue(1'b0, 16'd50000, 16'd3, t);
      for (int i = 0; i < 7; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sb.delete();
      tick();
      check_reset_outputs("abort");
      for (int i = 0; i < 20; i++) begin
         tick();
         if (s_valid) saw = 1'b1;
      end
      vectors++;
      if (saw) begin
         miscompares++;
         $display("FAIL abort_no_valid: valid seen after abort, required none");
      end
      issue(1'b1, 16'd40000, 16'd300, t);
      wait_valid(tv);
      vectors++;
      if (tv != t + 17 || s_q !== 16'd133 || s_r !== 16'd100 || s_id !== 1'b1) begin
         miscompares++;
         $display("FAIL after_abort: cycle %0d q=%0d r=%0d id=%b, required cycle %0d 133 100 1",
                  tv, s_q, s_r, s_id, t + 17);
      end
   endtask

   initial begin
      rst      = 1'b1;
      bus.req0 = 1'b0; bus.a0 = '0; bus.b0 = '0;
      bus.req1 = 1'b0; bus.a1 = '0; bus.b1 = '0;
      @(posedge clk);
      #1;
      test_reset();
      test_basic();
      test_req1();
      test_div0();
      test_round_robin();
      test_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
